id_alu_decode: RTL and testbench

- Decode stage that feeds the ALU. It accepts MIPS instructions from the fetch stage over a valid/allowin handshake.
- Reads the register file and decodes each instruction into the 16-bit one-hot alu_op and two 32-bit ALU operands.
- Results go into the ID/EX output register, with a RAW-hazard interlock.
- Sits between the IF stage and the EX stage, which drives the ALU directly from this block's outputs.

---
 rtl/id_alu_decode.sv | 209 ++++++++++++++++++++
 tb/tb_id_alu_decode.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_alu_decode.sv
// Instruction-decode stage feeding the ALU: decodes MIPS ALU instructions into a one-hot op and operands.
// It has a RAW interlock and registers its outputs. Define ALU_DECODE_STAT_EN to add the stall/illegal counters.
module id_alu_decode #(
    parameter int OP_W   = 16,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fs_to_ds_valid,
    output logic              ds_allowin,
    input  logic [31:0]       fs_inst,
    input  logic [31:0]       fs_pc,
    output logic [NREG_W-1:0] rf_raddr1,
    output logic [NREG_W-1:0] rf_raddr2,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    input  logic [NREG_W-1:0] ex_dest,
    input  logic [NREG_W-1:0] mem_dest,
    input  logic [NREG_W-1:0] wb_dest,
    input  logic              ex_we,
    input  logic              mem_we,
    input  logic              wb_we,
    input  logic              es_allowin,
    output logic              ds_to_es_valid,
    output logic [OP_W-1:0]   es_alu_op,
    output logic [31:0]       es_alu_src1,
    output logic [31:0]       es_alu_src2,
    output logic [NREG_W-1:0] es_dest,
    output logic              es_rf_we,
    output logic [31:0]       es_pc,
    output logic              es_illegal
`ifdef ALU_DECODE_STAT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       illegal_cnt
`endif
);

    logic [5:0]        opc;
    logic [5:0]        funct;
    logic [NREG_W-1:0] rs;
    logic [NREG_W-1:0] rt;
    logic [NREG_W-1:0] rd;
    logic [4:0]        sa;
    logic [15:0]       imm;

    assign opc   = fs_inst[31:26];
    assign rs    = fs_inst[25:21];
    assign rt    = fs_inst[20:16];
    assign rd    = fs_inst[15:11];
    assign sa    = fs_inst[10:6];
    assign funct = fs_inst[5:0];
    assign imm   = fs_inst[15:0];

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    logic              is_rtype;
    logic              illegal_d;
    logic              imm_sext;
    logic              shamt_src;
    logic              use_rs;
    logic              use_rt;
    logic [OP_W-1:0]   alu_op_d;
    logic [31:0]       src1_d;
    logic [31:0]       src2_d;
    logic [NREG_W-1:0] dest_d;
    logic              rf_we_d;

    always_comb begin
        is_rtype  = (opc == 6'h00);
        illegal_d = 1'b0;
        imm_sext  = 1'b0;
        shamt_src = 1'b0;
        use_rs    = 1'b1;
        use_rt    = is_rtype;
        alu_op_d  = '0;
        if (is_rtype) begin
            case (funct)
                6'h21: alu_op_d[0]  = 1'b1;
                6'h23: alu_op_d[1]  = 1'b1;
                6'h2A: alu_op_d[2]  = 1'b1;
                6'h2B: alu_op_d[3]  = 1'b1;
                6'h24: alu_op_d[4]  = 1'b1;
                6'h27: alu_op_d[5]  = 1'b1;
                6'h25: alu_op_d[6]  = 1'b1;
                6'h26: alu_op_d[7]  = 1'b1;
                6'h00: begin alu_op_d[8]  = 1'b1; shamt_src = 1'b1; use_rs = 1'b0; end
                6'h02: begin alu_op_d[9]  = 1'b1; shamt_src = 1'b1; use_rs = 1'b0; end
                6'h03: begin alu_op_d[10] = 1'b1; shamt_src = 1'b1; use_rs = 1'b0; end
                6'h04: alu_op_d[8]  = 1'b1;
                6'h06: alu_op_d[9]  = 1'b1;
                6'h07: alu_op_d[10] = 1'b1;
                default: illegal_d = 1'b1;
            endcase
        end else begin
            case (opc)
                6'h09: begin alu_op_d[0] = 1'b1; imm_sext = 1'b1; end
                6'h0A: begin alu_op_d[2] = 1'b1; imm_sext = 1'b1; end
                6'h0B: begin alu_op_d[3] = 1'b1; imm_sext = 1'b1; end
                6'h0C: alu_op_d[4]  = 1'b1;
                6'h0D: alu_op_d[6]  = 1'b1;
                6'h0E: alu_op_d[7]  = 1'b1;
                6'h0F: begin alu_op_d[11] = 1'b1; use_rs = 1'b0; end
                default: illegal_d = 1'b1;
            endcase
        end
        // An undecodable word reads nothing, so it can never stall the pipe.
        if (illegal_d) begin
            use_rs = 1'b0;
            use_rt = 1'b0;
        end
    end

    always_comb begin
        src1_d = '0;
        src2_d = '0;
        if (!illegal_d) begin
            src1_d = shamt_src ? {27'b0, sa} : rf_rdata1;
            if (is_rtype)
                src2_d = rf_rdata2;
            else if (imm_sext)
                src2_d = {{16{imm[15]}}, imm};
            else
                src2_d = {16'b0, imm};
        end
        dest_d  = is_rtype ? rd : rt;
        rf_we_d = !illegal_d && (dest_d != '0);
    end

    logic              valid_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [31:0]       src1_q;
    logic [31:0]       src2_q;
    logic [NREG_W-1:0] dest_q;
    logic              rf_we_q;
    logic [31:0]       pc_q;
    logic              illegal_q;

    logic rs_hit;
    logic rt_hit;
    logic hazard;
    logic accept;

    assign rs_hit = (valid_q && rf_we_q && dest_q == rs) || (ex_we && ex_dest == rs) ||
                    (mem_we && mem_dest == rs) || (wb_we && wb_dest == rs);
    assign rt_hit = (valid_q && rf_we_q && dest_q == rt) || (ex_we && ex_dest == rt) ||
                    (mem_we && mem_dest == rt) || (wb_we && wb_dest == rt);
    assign hazard = fs_to_ds_valid &&
                    ((use_rs && rs != '0 && rs_hit) || (use_rt && rt != '0 && rt_hit));

    assign ds_allowin = resetn && (!valid_q || es_allowin) && !hazard;
    assign accept     = fs_to_ds_valid && ds_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= 1'b0;
            alu_op_q  <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            dest_q    <= '0;
            rf_we_q   <= 1'b0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (!valid_q || es_allowin)
                valid_q <= fs_to_ds_valid && !hazard;
            if (accept) begin
                alu_op_q  <= alu_op_d;
                src1_q    <= src1_d;
                src2_q    <= src2_d;
                dest_q    <= dest_d;
                rf_we_q   <= rf_we_d;
                pc_q      <= fs_pc;
                illegal_q <= illegal_d;
            end
        end
    end

    assign ds_to_es_valid = valid_q;
    assign es_alu_op      = alu_op_q;
    assign es_alu_src1    = src1_q;
    assign es_alu_src2    = src2_q;
    assign es_dest        = dest_q;
    assign es_rf_we       = rf_we_q;
    assign es_pc          = pc_q;
    assign es_illegal     = illegal_q;

`ifdef ALU_DECODE_STAT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] illegal_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (hazard)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (accept && illegal_d)
                illegal_cnt_q <= illegal_cnt_q + 32'd1;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_id_alu_decode.sv
// Directed bench for id_alu_decode: expected entries are queued at issue and compared as EX takes them.
// The downstream ex/mem/wb destinations come from a small shift model of the later stages.
module tb_id_alu_decode;

    typedef struct packed {
        logic [15:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  dest;
        logic        we;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fs_to_ds_valid;
    logic        ds_allowin;
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [4:0]  ex_dest;
    logic [4:0]  mem_dest;
    logic [4:0]  wb_dest;
    logic        ex_we;
    logic        mem_we;
    logic        wb_we;
    logic        es_allowin;
    logic        ds_to_es_valid;
    logic [15:0] es_alu_op;
    logic [31:0] es_alu_src1;
    logic [31:0] es_alu_src2;
    logic [4:0]  es_dest;
    logic        es_rf_we;
    logic [31:0] es_pc;
    logic        es_illegal;
`ifdef ALU_DECODE_STAT_EN
    logic [31:0] stall_cnt;
    logic [31:0] illegal_cnt;
`endif

    int total = 0;
    int bad   = 0;
    exp_t sbq[$];
    logic [31:0] regs [32];

    always #5 clk = ~clk;

    id_alu_decode dut (
        .clk(clk), .resetn(resetn),
        .fs_to_ds_valid(fs_to_ds_valid), .ds_allowin(ds_allowin),
        .fs_inst(fs_inst), .fs_pc(fs_pc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
        .es_alu_op(es_alu_op), .es_alu_src1(es_alu_src1), .es_alu_src2(es_alu_src2),
        .es_dest(es_dest), .es_rf_we(es_rf_we), .es_pc(es_pc), .es_illegal(es_illegal)
`ifdef ALU_DECODE_STAT_EN
        , .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt)
`endif
    );

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    // Later pipeline stages: whatever EX takes moves down one stage per cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_dest <= '0; mem_dest <= '0; wb_dest <= '0;
            ex_we   <= 1'b0; mem_we <= 1'b0; wb_we <= 1'b0;
        end else begin
            ex_dest  <= (ds_to_es_valid && es_allowin) ? es_dest : 5'd0;
            ex_we    <= ds_to_es_valid && es_allowin && es_rf_we;
            mem_dest <= ex_dest;  mem_we <= ex_we;
            wb_dest  <= mem_dest; wb_we  <= mem_we;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && ds_to_es_valid && es_allowin) begin
            chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_op",   32'(es_alu_op), 32'(e.op));
                chk("sb_src1", es_alu_src1, e.s1);
                chk("sb_src2", es_alu_src2, e.s2);
                chk("sb_dest", 32'(es_dest), 32'(e.dest));
                chk("sb_we",   32'(es_rf_we), 32'(e.we));
                chk("sb_ill",  32'(es_illegal), 32'(e.ill));
                chk("sb_pc",   es_pc, e.pc);
            end
        end
    end

    function automatic exp_t mk(input logic [15:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [4:0] dest, input logic we, input logic ill);
        exp_t e;
        e.op = op; e.s1 = s1; e.s2 = s2; e.dest = dest; e.we = we; e.ill = ill; e.pc = '0;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction until accepted (bounded); returns the number of stall cycles.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e, output int waited);
        logic acc;
        exp_t ee;
        ee = e;
        ee.pc = pc;
        fs_inst = inst; fs_pc = pc; fs_to_ds_valid = 1'b1;
        sbq.push_back(ee);
        waited = 0;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            #1;
            if (ds_allowin) acc = 1'b1;
            else waited++;
            cyc();
        end
        chk("accept", 32'(acc), 32'd1);
        fs_to_ds_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(ds_to_es_valid), 32'd0);
        chk({tag, "_op"},    32'(es_alu_op), 32'd0);
        chk({tag, "_src1"},  es_alu_src1, 32'd0);
        chk({tag, "_src2"},  es_alu_src2, 32'd0);
        chk({tag, "_dest"},  32'(es_dest), 32'd0);
        chk({tag, "_we"},    32'(es_rf_we), 32'd0);
        chk({tag, "_pc"},    es_pc, 32'd0);
        chk({tag, "_ill"},   32'(es_illegal), 32'd0);
    endtask

    initial begin
        int w;
        int k;
        logic [31:0] cnt0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hDEAD_0000 | 32'(i);
        regs[0] = 32'd0;
        regs[1] = 32'h1111_1111;
        regs[3] = 32'h0000_0333;
        regs[5] = 32'h0000_0010;
        regs[6] = 32'h8000_0000;
        regs[8] = 32'h0000_F0F0;
        regs[9] = 32'h1234_5678;
        cnt0 = '0;
        w = 0;

        resetn = 1'b0; fs_to_ds_valid = 1'b0; fs_inst = '0; fs_pc = '0; es_allowin = 1'b1;
        #2;
        check_zero("reset");
        cyc();
        resetn = 1'b1;
        cyc();

        // ADDIU $2, $5, 0xFFFF
        send({6'h09, 5'd5, 5'd2, 16'hFFFF}, 32'h0040_0000,
             mk(16'h0001, 32'h10, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0), w);
        chk("addiu_valid", 32'(ds_to_es_valid), 32'd1);
        chk("addiu_op",    32'(es_alu_op), 32'h0001);
        chk("addiu_src2",  es_alu_src2, 32'hFFFF_FFFF);

        // SRA $4, $6, 4
        send({6'h00, 5'd0, 5'd6, 5'd4, 5'd4, 6'h03}, 32'h0040_0004,
             mk(16'h0400, 32'h4, 32'h8000_0000, 5'd4, 1'b1, 1'b0), w);
        chk("sra_valid", 32'(ds_to_es_valid), 32'd1);
        chk("sra_src1",  es_alu_src1, 32'h4);

        // Independent instructions back to back: no stall cycles expected.
        send({6'h0D, 5'd8, 5'd10, 16'h8001}, 32'h0040_0008,
             mk(16'h0040, regs[8], 32'h0000_8001, 5'd10, 1'b1, 1'b0), w);
        chk("ori_nostall", w, 0);
        send({6'h0A, 5'd9, 5'd11, 16'h8000}, 32'h0040_000C,
             mk(16'h0004, regs[9], 32'hFFFF_8000, 5'd11, 1'b1, 1'b0), w);
        chk("slti_nostall", w, 0);
        send({6'h0F, 5'd0, 5'd12, 16'h1234}, 32'h0040_0010,
             mk(16'h0800, 32'h0, 32'h0000_1234, 5'd12, 1'b1, 1'b0), w);
        chk("lui_nostall", w, 0);
        send({6'h00, 5'd1, 5'd8, 5'd13, 5'd0, 6'h27}, 32'h0040_0014,
             mk(16'h0020, regs[1], regs[8], 5'd13, 1'b1, 1'b0), w);
        chk("nor_nostall", w, 0);
        send({6'h00, 5'd5, 5'd9, 5'd14, 5'd0, 6'h04}, 32'h0040_0018,
             mk(16'h0100, regs[5], regs[9], 5'd14, 1'b1, 1'b0), w);
        chk("sllv_nostall", w, 0);
        send({6'h00, 5'd1, 5'd6, 5'd0, 5'd0, 6'h26}, 32'h0040_001C,
             mk(16'h0080, regs[1], regs[6], 5'd0, 1'b0, 1'b0), w);
        chk("xor_r0_nostall", w, 0);
        send({6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h3F}, 32'h0040_0020,
             mk(16'h0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1), w);
        chk("badfunct_nostall", w, 0);
        for (int i = 0; i < 5; i++) cyc();

        // Backpressure: hold EX off for three cycles with a follow-on instruction waiting.
        send({6'h0D, 5'd1, 5'd16, 16'h0005}, 32'h0040_0100,
             mk(16'h0040, regs[1], 32'h5, 5'd16, 1'b1, 1'b0), w);
        es_allowin = 1'b0;
        fs_inst = {6'h09, 5'd8, 5'd17, 16'h0001}; fs_pc = 32'h0040_0104; fs_to_ds_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_allowin", 32'(ds_allowin), 32'd0);
            chk("bp_valid",   32'(ds_to_es_valid), 32'd1);
            chk("bp_op",      32'(es_alu_op), 32'h0040);
            chk("bp_src2",    es_alu_src2, 32'h5);
            chk("bp_pc",      es_pc, 32'h0040_0100);
            cyc();
        end
        es_allowin = 1'b1;
        sbq.push_back(exp_t'{16'h0001, regs[8], 32'h1, 5'd17, 1'b1, 1'b0, 32'h0040_0104});
        #1;
        chk("bp_release_allowin", 32'(ds_allowin), 32'd1);
        cyc();
        fs_to_ds_valid = 1'b0;
        chk("bp_next_valid", 32'(ds_to_es_valid), 32'd1);
        chk("bp_next_pc",    es_pc, 32'h0040_0104);
        for (int i = 0; i < 5; i++) cyc();

        // RAW interlock: SUBU reads $3 while ADDU's write walks out through out-reg/ex/mem/wb.
        send({6'h00, 5'd1, 5'd8, 5'd3, 5'd0, 6'h21}, 32'h0040_0200,
             mk(16'h0001, regs[1], regs[8], 5'd3, 1'b1, 1'b0), w);
        chk("addu_nostall", w, 0);
`ifdef ALU_DECODE_STAT_EN
        cnt0 = stall_cnt;
`endif
        fs_inst = {6'h00, 5'd3, 5'd1, 5'd7, 5'd0, 6'h23}; fs_pc = 32'h0040_0204; fs_to_ds_valid = 1'b1;
        sbq.push_back(exp_t'{16'h0002, regs[3], regs[1], 5'd7, 1'b1, 1'b0, 32'h0040_0204});
        k = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("raw_allowin", 32'(ds_allowin), (i < 4) ? 32'd0 : 32'd1);
            chk("raw_valid",   32'(ds_to_es_valid), (i == 0) ? 32'd1 : 32'd0);
            cyc();
            k++;
        end
        fs_to_ds_valid = 1'b0;
        chk("raw_cycles", k, 5);
        chk("subu_valid", 32'(ds_to_es_valid), 32'd1);
        chk("subu_op",    32'(es_alu_op), 32'h0002);
`ifdef ALU_DECODE_STAT_EN
        chk("stall_cnt_delta", stall_cnt - cnt0, 32'd4);
        cnt0 = illegal_cnt;
`endif

        // Opcode 0x3F is not decodable.
        send({6'h3F, 26'd0}, 32'h0040_0300, mk(16'h0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1), w);
        chk("ill_valid", 32'(ds_to_es_valid), 32'd1);
        chk("ill_flag",  32'(es_illegal), 32'd1);
        chk("ill_op",    32'(es_alu_op), 32'd0);
        chk("ill_we",    32'(es_rf_we), 32'd0);
`ifdef ALU_DECODE_STAT_EN
        chk("illegal_cnt_delta", illegal_cnt - cnt0, 32'd1);
`endif
        cyc();

        // Asynchronous reset mid-stream with a live entry and a pending instruction.
        send({6'h0D, 5'd1, 5'd18, 16'h0007}, 32'h0040_0400,
             mk(16'h0040, regs[1], 32'h7, 5'd18, 1'b1, 1'b0), w);
        fs_inst = {6'h0E, 5'd9, 5'd19, 16'h00FF}; fs_pc = 32'h0040_0404; fs_to_ds_valid = 1'b1;
        chk("pre_rst_valid", 32'(ds_to_es_valid), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check_zero("midrst");
        sbq.delete();
`ifdef ALU_DECODE_STAT_EN
        chk("rst_stall_cnt",   stall_cnt, 32'd0);
        chk("rst_illegal_cnt", illegal_cnt, 32'd0);
`endif
        fs_to_ds_valid = 1'b0;
        cyc();
        resetn = 1'b1;
        cyc();
        send({6'h09, 5'd5, 5'd2, 16'hFFFF}, 32'h0040_0500,
             mk(16'h0001, 32'h10, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0), w);
        chk("post_rst_valid", 32'(ds_to_es_valid), 32'd1);
        chk("post_rst_src1",  es_alu_src1, 32'h10);
        chk("post_rst_pc",    es_pc, 32'h0040_0500);

        for (int i = 0; i < 4; i++) cyc();
        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
